// File: rtl/tl_uh_memory_responder.sv
// TileLink-UH memory responder: terminates the data-cache A/D channels against
// an internal word-addressed SRAM. Supports Get, PutFullData, PutPartialData
// (single beat or bursts up to 32 bytes) and Intent, with one transaction
// outstanding at a time.
module tl_uh_memory_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    input  logic        a_valid,
    output logic        a_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt,
    output logic        d_valid,
    input  logic        d_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Address window as 33-bit values so BASE + 4*DEPTH cannot wrap.
    localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    localparam logic [2:0] OP_PUT_FULL  = 3'd0;
    localparam logic [2:0] OP_PUT_PART  = 3'd1;
    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] OP_INTENT    = 3'd5;
    localparam logic [2:0] OP_ACCESSACK = 3'd0;
    localparam logic [2:0] OP_ACKDATA   = 3'd1;
    localparam logic [2:0] OP_HINTACK   = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_ACK
    } state_t;

    state_t        state;
    logic          a_ready_q;
    logic [3:0]    size_q;
    logic [AW-1:0] word_q;
    logic          deny_q;
    logic [2:0]    cnt;
    logic [2:0]    last_q;
    logic          rd_gate;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word;

    logic          a_fire;
    logic          d_fire;
    logic [31:0]   offset;
    logic [AW-1:0] a_word;
    logic [31:0]   align_mask;
    logic          in_range;
    logic          misalign;
    logic          op_ok;
    logic          a_deny;
    logic [2:0]    a_last;

    logic          we;
    logic          re;
    logic [AW-1:0] widx;
    logic [AW-1:0] ridx;

    logic          unused_bits;

    // No handshake completes while reset is held, even though a_ready_q
    // already carries its post-reset value.
    assign a_ready  = a_ready_q & ~cpu_rst_i;
    assign a_fire   = a_valid & a_ready;
    assign d_fire   = d_valid & d_ready;
    assign d_param  = 2'b00;
    assign d_data   = rd_gate ? rd_word : 32'h0;

    assign offset      = a_address - BASE_ADDR;
    assign a_word      = offset[AW+1:2];
    assign align_mask  = (32'd1 << a_size) - 32'd1;
    assign in_range    = ({1'b0, a_address} >= LO_ADDR) && ({1'b0, a_address} < HI_ADDR);
    assign misalign    = |(a_address & align_mask);
    assign op_ok       = a_opcode inside {OP_PUT_FULL, OP_PUT_PART, OP_GET, OP_INTENT};
    assign a_deny      = !in_range || misalign || (a_size > 4'd5) || !op_ok;
    assign unused_bits = ^{a_param, offset};

    // Index of the final beat of a burst; oversize requests collapse to one beat.
    always_comb begin
        a_last = 3'd0;
        case (a_size)
            4'd3:    a_last = 3'd1;
            4'd4:    a_last = 3'd3;
            4'd5:    a_last = 3'd7;
            default: a_last = 3'd0;
        endcase
    end

    // SRAM port control: writes on accepted Put beats, reads on Get accept and D fires.
    always_comb begin
        we   = 1'b0;
        re   = 1'b0;
        widx = word_q + AW'(cnt);
        ridx = word_q + AW'(cnt) + AW'(1);
        case (state)
            S_IDLE: begin
                widx = a_word;
                ridx = a_word;
                if (a_fire) begin
                    we = ((a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART))
                         && !a_deny && !a_corrupt;
                    re = (a_opcode == OP_GET);
                end
            end
            S_WRITE: begin
                we = a_fire && !deny_q && !a_corrupt;
            end
            S_READ: begin
                re = d_fire && (cnt != last_q);
            end
            default: begin
                we = 1'b0;
                re = 1'b0;
            end
        endcase
    end

    // SRAM array with byte-lane writes and a registered read port; never reset.
    always_ff @(posedge cpu_clk_i) begin
        if (we && !cpu_rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    mem[widx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
        if (re && !cpu_rst_i) begin
            rd_word <= mem[ridx];
        end
    end

    // Transaction FSM with registered A-ready and D-channel outputs.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state     <= S_IDLE;
            a_ready_q <= 1'b1;
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 4'd0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
            rd_gate   <= 1'b0;
            size_q    <= 4'd0;
            word_q    <= '0;
            deny_q    <= 1'b0;
            cnt       <= 3'd0;
            last_q    <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (a_fire) begin
                        size_q <= a_size;
                        word_q <= a_word;
                        deny_q <= a_deny;
                        last_q <= a_last;
                        cnt    <= 3'd0;
                        case (a_opcode)
                            OP_GET: begin
                                state     <= S_READ;
                                a_ready_q <= 1'b0;
                                d_valid   <= 1'b1;
                                d_opcode  <= OP_ACKDATA;
                                d_size    <= a_size;
                                d_denied  <= a_deny;
                                d_corrupt <= a_deny;
                                rd_gate   <= !a_deny;
                            end
                            OP_PUT_FULL, OP_PUT_PART: begin
                                if (a_last == 3'd0) begin
                                    state     <= S_ACK;
                                    a_ready_q <= 1'b0;
                                    d_valid   <= 1'b1;
                                    d_opcode  <= OP_ACCESSACK;
                                    d_size    <= a_size;
                                    d_denied  <= a_deny;
                                    d_corrupt <= 1'b0;
                                    rd_gate   <= 1'b0;
                                end else begin
                                    state <= S_WRITE;
                                    cnt   <= 3'd1;
                                end
                            end
                            OP_INTENT: begin
                                state     <= S_ACK;
                                a_ready_q <= 1'b0;
                                d_valid   <= 1'b1;
                                d_opcode  <= OP_HINTACK;
                                d_size    <= a_size;
                                d_denied  <= a_deny;
                                d_corrupt <= 1'b0;
                                rd_gate   <= 1'b0;
                            end
                            default: begin
                                state     <= S_ACK;
                                a_ready_q <= 1'b0;
                                d_valid   <= 1'b1;
                                d_opcode  <= OP_ACCESSACK;
                                d_size    <= a_size;
                                d_denied  <= 1'b1;
                                d_corrupt <= 1'b0;
                                rd_gate   <= 1'b0;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (a_fire) begin
                        if (cnt == last_q) begin
                            state     <= S_ACK;
                            a_ready_q <= 1'b0;
                            d_valid   <= 1'b1;
                            d_opcode  <= OP_ACCESSACK;
                            d_size    <= size_q;
                            d_denied  <= deny_q;
                            d_corrupt <= 1'b0;
                            rd_gate   <= 1'b0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_READ: begin
                    if (d_fire) begin
                        if (cnt == last_q) begin
                            state     <= S_IDLE;
                            a_ready_q <= 1'b1;
                            d_valid   <= 1'b0;
                            d_opcode  <= 3'd0;
                            d_size    <= 4'd0;
                            d_denied  <= 1'b0;
                            d_corrupt <= 1'b0;
                            rd_gate   <= 1'b0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (d_fire) begin
                        state     <= S_IDLE;
                        a_ready_q <= 1'b1;
                        d_valid   <= 1'b0;
                        d_opcode  <= 3'd0;
                        d_size    <= 4'd0;
                        d_denied  <= 1'b0;
                        d_corrupt <= 1'b0;
                        rd_gate   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
